// File: rtl/spi_output_controller.sv
// SPI slave transmit side: answers a received command byte with cost, digit or 0xFF on MISO,
// LSB first, shifting on synchronized SCK rising edges.
module spi_output_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       SS,
    input  logic       shift_SPI,
    input  logic [7:0] SPI_in,
    input  logic       data_ready,
    input  logic       cost_ready,
    input  logic [7:0] cost_output,
    input  logic       network_done,
    input  logic [3:0] detected_digit,
    output logic       MISO
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    localparam logic [7:0] CmdCost  = 8'h01;
    localparam logic [7:0] CmdDigit = 8'h02;

    state_e      state_q, state_d;
    logic [1:0]  sck_sync_q;
    logic        sck_prev_q;
    logic        sck_rise;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        miso_q, miso_d;
    logic [3:0]  digit_q;
    logic        digit_valid_q;
    logic [3:0]  snap_digit_q, snap_digit_d;
    logic        snap_valid_q, snap_valid_d;
    logic [7:0]  payload;

    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
    assign MISO     = miso_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q    <= 2'b00;
            sck_prev_q    <= 1'b0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], SCK};
            sck_prev_q <= sck_sync_q[1];
            if (network_done) begin
                digit_q       <= detected_digit;
                digit_valid_q <= 1'b1;
            end
        end
    end

    // The digit is snapshotted at command acceptance so a coincident network_done
    // does not alter the response to that command.
    always_comb begin
        payload = 8'hFF;
        case (cmd_q)
            CmdCost:  if (data_ready && cost_ready) payload = cost_output;
            CmdDigit: if (data_ready && snap_valid_q) payload = {4'b0000, snap_digit_q};
            default:  payload = 8'hFF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        snap_digit_d = snap_digit_q;
        snap_valid_d = snap_valid_q;
        if (SS) begin
            state_d = StIdle;
            cmd_d   = 8'h00;
            cnt_d   = 4'd0;
            shift_d = 8'hFF;
        end else begin
            case (state_q)
                StIdle: begin
                    shift_d = 8'hFF;
                    cnt_d   = 4'd0;
                    if (shift_SPI) begin
                        cmd_d        = SPI_in;
                        snap_digit_d = digit_q;
                        snap_valid_d = digit_valid_q;
                        state_d      = StLoad;
                    end
                end
                StLoad: begin
                    shift_d = payload;
                    if (sck_rise) begin
                        shift_d = {1'b1, shift_q[7:1]};
                        cnt_d   = 4'd1;
                        state_d = StSend;
                    end
                end
                StSend: begin
                    if (sck_rise) begin
                        shift_d = {1'b1, shift_q[7:1]};
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        miso_d = (state_d == StIdle) ? 1'b1 : shift_d[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cmd_q        <= 8'h00;
            shift_q      <= 8'hFF;
            cnt_q        <= 4'd0;
            miso_q       <= 1'b1;
            snap_digit_q <= 4'd0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            snap_digit_q <= snap_digit_d;
            snap_valid_q <= snap_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_output_controller.sv
// Randomized bench for spi_output_controller: an SPI master model assembles MISO bytes and
// compares them against responses derived from the command/result rules.
module tb_spi_output_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCK = 1'b0;
    logic       SS = 1'b0;
    logic       shift_SPI = 1'b0;
    logic [7:0] SPI_in = 8'h00;
    logic       data_ready = 1'b0;
    logic       cost_ready = 1'b0;
    logic [7:0] cost_output = 8'h00;
    logic       network_done = 1'b0;
    logic [3:0] detected_digit = 4'd0;
    logic       MISO;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: the digit register as seen by the master
    logic [3:0] m_digit = 4'd0;
    logic       m_valid = 1'b0;

    spi_output_controller dut (
        .clk            (clk),
        .rst            (rst),
        .SCK            (SCK),
        .SS             (SS),
        .shift_SPI      (shift_SPI),
        .SPI_in         (SPI_in),
        .data_ready     (data_ready),
        .cost_ready     (cost_ready),
        .cost_output    (cost_output),
        .network_done   (network_done),
        .detected_digit (detected_digit),
        .MISO           (MISO)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_resp(input logic [7:0] c, input logic dr, input logic cr,
                                            input logic [7:0] cost, input logic dv,
                                            input logic [3:0] dg);
        if (c == 8'h01) return (dr && cr) ? cost : 8'hFF;
        if (c == 8'h02) return (dr && dv) ? {4'd0, dg} : 8'hFF;
        return 8'hFF;
    endfunction

    // Issue a command; with_done also pulses network_done in the same cycle.
    task automatic send_cmd(input logic [7:0] c, input logic with_done, input logic [3:0] d,
                            output logic snap_v, output logic [3:0] snap_d);
        @(negedge clk);
        snap_v    = m_valid;
        snap_d    = m_digit;
        shift_SPI = 1'b1;
        SPI_in    = c;
        if (with_done) begin
            network_done   = 1'b1;
            detected_digit = d;
            m_digit        = d;
            m_valid        = 1'b1;
        end
        @(negedge clk);
        shift_SPI    = 1'b0;
        network_done = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] d);
        @(negedge clk);
        network_done   = 1'b1;
        detected_digit = d;
        @(negedge clk);
        network_done = 1'b0;
        m_digit      = d;
        m_valid      = 1'b1;
    endtask

    // Master side of one byte. stop_kind: 0 full byte, 1 SS abort, 2 reset abort before bit stop_at.
    task automatic xfer(input string tag, input logic [7:0] exp, input int stop_at,
                        input int stop_kind, input bit dummies, input bit new_cost_en,
                        input logic [7:0] new_cost);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (stop_kind != 0 && i == stop_at) begin
                check_eq({tag, "_partial"}, 32'(b >> (8 - i)), 32'(exp & ((8'd1 << i) - 8'd1)));
                if (stop_kind == 1) SS = 1'b1;
                else rst = 1'b1;
                repeat (2) @(negedge clk);
                check_eq({tag, "_abort_miso"}, 32'(MISO), 32'd1);
                if (stop_kind == 2) begin
                    m_digit = 4'd0;
                    m_valid = 1'b0;
                end
                SS  = 1'b0;
                rst = 1'b0;
                repeat (2) @(negedge clk);
                check_eq({tag, "_after_abort_miso"}, 32'(MISO), 32'd1);
                return;
            end
            repeat (5) @(negedge clk);
            b   = {MISO, b[7:1]};
            SCK = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (k == 0 && dummies) begin
                    shift_SPI = 1'b1;
                    SPI_in    = (($urandom & 1) != 0) ? 8'hFF : 8'h02;
                end else begin
                    shift_SPI = 1'b0;
                end
                if (k == 4 && i == 0 && new_cost_en) cost_output = new_cost;
            end
            SCK = 1'b0;
        end
        check_eq(tag, 32'(b), 32'(exp));
        repeat (3) @(negedge clk);
        check_eq({tag, "_idle_miso"}, 32'(MISO), 32'd1);
    endtask

    initial begin
        logic       sv;
        logic [3:0] sd;
        logic [7:0] c;
        logic [7:0] e;
        logic       wd;
        logic [3:0] dd;

        repeat (3) @(negedge clk);
        check_eq("reset_miso", 32'(MISO), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_miso", 32'(MISO), 32'd1);

        // Cost read, value 133
        data_ready = 1'b1;
        cost_ready = 1'b1;
        cost_output = 8'd133;
        send_cmd(8'h01, 1'b0, 4'd0, sv, sd);
        xfer("cost133", 8'd133, 0, 0, 1'b0, 1'b0, 8'h00);

        cost_ready = 1'b0;
        send_cmd(8'h01, 1'b0, 4'd0, sv, sd);
        xfer("cost_not_ready", 8'hFF, 0, 0, 1'b0, 1'b0, 8'h00);

        // No-op with coincident network_done (digit 0), then digit read
        send_cmd(8'h00, 1'b1, 4'd0, sv, sd);
        xfer("noop", 8'hFF, 0, 0, 1'b0, 1'b0, 8'h00);
        detected_digit = 4'd7;
        send_cmd(8'h02, 1'b0, 4'd0, sv, sd);
        xfer("digit0", ref_resp(8'h02, 1'b1, 1'b0, 8'h00, sv, sd), 0, 0, 1'b0, 1'b0, 8'h00);

        pulse_done(4'd7);
        send_cmd(8'h02, 1'b0, 4'd0, sv, sd);
        xfer("digit7", 8'h07, 0, 0, 1'b0, 1'b0, 8'h00);
        data_ready = 1'b0;
        send_cmd(8'h02, 1'b0, 4'd0, sv, sd);
        xfer("digit_not_ready", 8'hFF, 0, 0, 1'b0, 1'b0, 8'h00);

        // Coincident done + read digit responds with the old digit
        data_ready = 1'b1;
        send_cmd(8'h02, 1'b1, 4'd9, sv, sd);
        xfer("digit_old", 8'h07, 0, 0, 1'b0, 1'b0, 8'h00);

        // SS abort after 3 bits, then a clean 0x5A with dummy pulses during SEND
        cost_ready  = 1'b1;
        cost_output = 8'h5A;
        send_cmd(8'h01, 1'b0, 4'd0, sv, sd);
        xfer("ss_abort", 8'h5A, 3, 1, 1'b0, 1'b0, 8'h00);
        send_cmd(8'h01, 1'b0, 4'd0, sv, sd);
        xfer("cost5a", 8'h5A, 0, 0, 1'b1, 1'b0, 8'h00);

        // Payload frozen after first shift
        send_cmd(8'h01, 1'b0, 4'd0, sv, sd);
        xfer("frozen", 8'h5A, 0, 0, 1'b0, 1'b1, 8'hC3);

        // Reset mid-SEND clears the digit register
        send_cmd(8'h02, 1'b0, 4'd0, sv, sd);
        xfer("rst_abort", 8'h09, 4, 2, 1'b0, 1'b0, 8'h00);
        send_cmd(8'h02, 1'b0, 4'd0, sv, sd);
        xfer("digit_after_rst", 8'hFF, 0, 0, 1'b0, 1'b0, 8'h00);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(4))
                0: c = 8'h01;
                1: c = 8'h02;
                2: c = 8'h00;
                3: c = 8'hFF;
                default: c = 8'($urandom);
            endcase
            if ($urandom_range(9) < 2 && c == 8'h01) c = 8'h01;
            data_ready  = ($urandom_range(3) != 0);
            cost_ready  = ($urandom_range(3) != 0);
            cost_output = 8'($urandom);
            if ($urandom_range(2) == 0) pulse_done(4'($urandom_range(15)));
            wd = ($urandom_range(4) == 0);
            dd = 4'($urandom_range(15));
            send_cmd(c, wd, dd, sv, sd);
            e = ref_resp(c, data_ready, cost_ready, cost_output, sv, sd);
            if ($urandom_range(7) == 0)
                xfer("rand_ss", e, int'($urandom_range(1, 7)), 1, 1'b0, 1'b0, 8'h00);
            else
                xfer("rand", e, 0, 0, bit'($urandom & 1), bit'($urandom & 1), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
